prog_loader: RTL
================

Name: prog_loader

Overview:
- Writer side of the instruction memory, which the program counter reads.
- Accepts a byte stream over a valid/ready handshake and packs bytes into 32-bit little-endian instruction words.
- Writes words sequentially into instruction memory from address 0 and holds the CPU stopped while loading.
- Releases the CPU after a complete load and reports an XOR checksum of the written words.

Parameters:
- ADDR_W, 8, instruction memory address width (matches the 8-bit PC).
- WORD_W, 32, instruction width.
- BYTE_W, 8, stream symbol width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_req  input  1  single-cycle pulse that starts a load; sampled only in IDLE.
- load_len  input  ADDR_W+1  number of words to load, 1..256; captured with load_req.
- abort  input  1  cancels an in-progress load.
- in_valid  input  1  byte available on in_data.
- in_data  input  BYTE_W  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  WORD_W  write data.
- cpu_run  output  1  high means the CPU may run; drives the CPU reset/hold gating.
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  sticky error flag; cleared by the next accepted load_req.
- checksum  output  WORD_W  XOR of all words written in the current or last load.

Behaviour:
- Reset is asynchronous on rst_n low. State goes to IDLE; every output is 0, including cpu_run (CPU held until the first good load). Internal counters, byte index and shift register are all 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - On load_req with load_len in 1..256: capture the length; clear word count, byte index, addr, checksum and err; drop cpu_run to 0; go to RECV.
  - On load_req with load_len==0 or >256: set err=1, stay in IDLE, leave cpu_run unchanged.
- RECV:
  - in_ready=1. A byte transfers on a cycle with in_valid and in_ready both high.
  - Byte k of a word (k=0..3) goes into bits [8k+7:8k], little-endian.
  - When the 4th byte transfers, go to WRITE next cycle; no byte can be lost.
  - in_valid low stalls indefinitely with no timeout.
- WRITE (exactly one cycle):
  - in_ready=0, imem_we=1, imem_addr=current word count, imem_wdata=assembled word.
  - checksum updates to checksum XOR word in the same edge.
  - Word count increments. If the new count equals load_len go to DONE, else go to RECV with byte index 0.
- DONE (one cycle): done=1 and cpu_run set to 1 at the exit edge; go to IDLE.
- busy=1 in RECV, WRITE and DONE.
- Write latency: the imem_we cycle immediately follows the cycle in which the 4th byte of that word transferred.
- Address wrap: load_len=256 writes addresses 0..255. The counter is ADDR_W+1 bits wide so the compare does not alias; imem_addr is the low ADDR_W bits.
- abort:
  - In RECV or WRITE: go to IDLE next edge; err=1, cpu_run stays 0, a partial word is discarded.
  - Abort in a WRITE cycle still lets that write complete.
  - Abort in DONE or IDLE is ignored.
- load_req while busy is ignored.
- Simultaneous load_req and abort in IDLE: load_req wins.
- Memory contents beyond load_len are untouched.
- Reset mid-load: immediate IDLE, cpu_run=0, err=0; memory keeps any words already written.

Decomposition:
- Shared package: state encoding constants (IDLE, RECV, WRITE, DONE), ADDR_W/WORD_W/BYTE_W defaults, MAX_WORDS=256.
- One natural sub-module: byte_packer. It holds the 2-bit byte index and the 32-bit shift register, takes valid/data/clear, and outputs word_ready and word. The FSM and counters stay in prog_loader.

Test Plan:
- Reset then idle: all outputs 0 (cpu_run=0), in_ready=0.
- load_req with load_len=2 and bytes 78 56 34 12 EF BE AD DE sent back-to-back: writes addr0=0x12345678 and addr1=0xDEADBEEF; checksum=0xCC99E897; done pulses one cycle after the second write; cpu_run=1 afterwards; err=0.
- Same load with in_valid toggling every other cycle: identical writes, and every imem_we falls on the cycle after its word's 4th accepted byte.
- load_len=256 with 1024 bytes: last write at addr 255, no write to addr 0 after it, done asserted once.
- abort after 6 bytes of a 2-word load: one write only (addr0), no second write, err=1, cpu_run=0, state IDLE. A following valid load_req clears err.
- load_req with load_len=0: err=1, in_ready stays 0, no imem_we. Separately, pulse rst_n low mid-RECV: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default widths,
// FSM state encoding and the load length check.
package prog_loader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int MAX_WORDS  = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A length of zero or more than the memory depth cannot be loaded.
  function automatic logic len_ok(input int unsigned len);
    return (len != 0) && (len <= MAX_WORDS);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and instruction-memory write port out of the loader.
// slave is the loader side, master is the stream source / memory observer.
interface prog_loader_if #(
  parameter int ADDR_W = prog_loader_pkg::DEF_ADDR_W,
  parameter int WORD_W = prog_loader_pkg::DEF_WORD_W,
  parameter int BYTE_W = prog_loader_pkg::DEF_BYTE_W
);

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted stream bytes into little-endian words; the first byte of a
// word ends up in the least significant position.
module prog_loader_byte_packer #(
  parameter int WORD_W = prog_loader_pkg::DEF_WORD_W,
  parameter int BYTE_W = prog_loader_pkg::DEF_BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              valid,
  input  logic [BYTE_W-1:0] data,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);

  localparam int NB = WORD_W / BYTE_W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [IW-1:0]     idx_q;
  logic [WORD_W-1:0] sr_q;

  // Combinational so the FSM can leave RECV on the same edge that takes the last byte.
  assign word_ready = valid && (idx_q == IW'(NB - 1));
  assign word       = sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else if (clear) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else if (valid) begin
      sr_q  <= {data, sr_q[WORD_W-1:BYTE_W]};
      idx_q <= word_ready ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into instruction memory from address 0, holding the
// CPU stopped until a complete load has been written.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for load_req; cpu_run reflects the last load
//   ST_RECV  | accepting bytes until a full word is assembled
//   ST_WRITE | one-cycle memory write of the assembled word
//   ST_DONE  | one-cycle completion pulse, CPU released on exit
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  prog_loader_if.slave      bus,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] checksum
);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_next;
  logic [WORD_W-1:0] word;
  logic              word_ready;
  logic              xfer;
  logic              req_good;
  logic              pk_clear;

  assign req_good = load_req && len_ok(int'(load_len));
  assign xfer     = bus.in_valid && bus.in_ready;
  assign cnt_next = cnt_q + 1'b1;
  // The packer restarts on every idle cycle and drops a partial word on abort.
  assign pk_clear = (state_q == ST_IDLE) ||
                    (abort && (state_q == ST_RECV || state_q == ST_WRITE));

  prog_loader_byte_packer #(
    .WORD_W (WORD_W),
    .BYTE_W (BYTE_W)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .valid      (xfer),
    .data       (bus.in_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.in_ready   = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_addr  = cnt_q[ADDR_W-1:0];
    bus.imem_wdata = word;
    busy           = 1'b1;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (req_good) state_d = ST_RECV;
      end
      ST_RECV: begin
        bus.in_ready = 1'b1;
        if (abort)           state_d = ST_IDLE;
        else if (word_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        bus.imem_we = 1'b1;
        if (abort)                 state_d = ST_IDLE;
        else if (cnt_next == len_q) state_d = ST_DONE;
        else                        state_d = ST_RECV;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      cnt_q    <= '0;
      checksum <= '0;
      err      <= 1'b0;
      cpu_run  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_good) begin
            len_q    <= load_len;
            cnt_q    <= '0;
            checksum <= '0;
            err      <= 1'b0;
            cpu_run  <= 1'b0;
          end else if (load_req) begin
            err <= 1'b1;
          end
        end
        ST_RECV: begin
          if (abort) err <= 1'b1;
        end
        ST_WRITE: begin
          // An abort here still lets the word land, so it is folded into the checksum.
          checksum <= checksum ^ word;
          cnt_q    <= cnt_next;
          if (abort) err <= 1'b1;
        end
        ST_DONE: cpu_run <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
